// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART SETUP-programming APB sequencer.
// Defining CFG_READBACK_EN adds the SETUP read-back states and the mismatch mask.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_SETUP,
    S_POLL_ACCESS,
    S_WR_SETUP,
    S_WR_ACCESS,
`ifdef CFG_READBACK_EN
    S_RD_SETUP,
    S_RD_ACCESS,
`endif
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SLVERR   = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_MISMATCH = 2'b11
  } err_code_e;

  localparam int unsigned STATUS_OFS = 32'h20;
  localparam int unsigned SETUP_OFS  = 32'h24;

  localparam int STATUS_TX_BUSY_BIT = 0;
  localparam int STATUS_RX_BUSY_BIT = 1;
  localparam logic [31:0] STATUS_BUSY_MASK =
    (32'd1 << STATUS_TX_BUSY_BIT) | (32'd1 << STATUS_RX_BUSY_BIT);

  localparam int SETUP_CLKDIV_LSB = 16;
  localparam int SETUP_RXEN_BIT   = 9;
  localparam int SETUP_TXEN_BIT   = 8;
  localparam int SETUP_STOP_BIT   = 3;
  localparam int SETUP_BITS_LSB   = 1;
  localparam int SETUP_PARITY_BIT = 0;

`ifdef CFG_READBACK_EN
  // Only the fields we program are compared on read-back.
  localparam logic [31:0] SETUP_RB_MASK = 32'hFFFF_030F;
`endif

  typedef struct packed {
    logic [15:0] clkdiv;
    logic        rxen;
    logic        txen;
    logic        stop;
    logic [1:0]  bits;
    logic        parity;
  } setup_cfg_t;

  function automatic logic [31:0] pack_setup(input setup_cfg_t cfg);
    logic [31:0] w;
    w = '0;
    w[SETUP_CLKDIV_LSB +: 16] = cfg.clkdiv;
    w[SETUP_RXEN_BIT]         = cfg.rxen;
    w[SETUP_TXEN_BIT]         = cfg.txen;
    w[SETUP_STOP_BIT]         = cfg.stop;
    w[SETUP_BITS_LSB +: 2]    = cfg.bits;
    w[SETUP_PARITY_BIT]       = cfg.parity;
    return w;
  endfunction

endpackage

// File: rtl/uart_cfg_apb_sequencer_if.sv
// Config-request port plus APB master bus of the UART SETUP sequencer.
interface uart_cfg_apb_sequencer_if #(
  parameter int APB_AW = 12
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [15:0]       req_clkdiv_i;
  logic [1:0]        req_bits_i;
  logic              req_parity_i;
  logic              req_stop_i;
  logic              req_txen_i;
  logic              req_rxen_i;
  logic              done_o;
  logic              err_o;
  logic [1:0]        err_code_o;
  logic [APB_AW-1:0] paddr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [31:0]       pwdata_o;
  logic [31:0]       prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    input  req_valid_i, req_clkdiv_i, req_bits_i, req_parity_i, req_stop_i,
           req_txen_i, req_rxen_i, prdata_i, pready_i, pslverr_i,
    output req_ready_o, done_o, err_o, err_code_o,
           paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_clkdiv_i, req_bits_i, req_parity_i, req_stop_i,
           req_txen_i, req_rxen_i, prdata_i, pready_i, pslverr_i,
    input  req_ready_o, done_o, err_o, err_code_o,
           paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/uart_cfg_apb_xfer.sv
// Single APB read or write: start marks the SETUP phase, ACCESS runs until pready_i
// or the wait limit, and done/err/rdata are presented in the final ACCESS cycle.
module uart_cfg_apb_xfer
  import uart_cfg_pkg::*;
#(
  parameter int APB_AW     = 12,
  parameter int PREADY_MAX = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic              we,
  input  logic [APB_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output err_code_e         err,
  output logic [APB_AW-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int WW = $clog2(PREADY_MAX + 1);

  logic              access_q;
  logic              we_q;
  logic [APB_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [WW-1:0]     wait_q;
  logic              timeout;

  assign timeout = access_q && !pready && (wait_q == WW'(PREADY_MAX - 1));
  assign done    = access_q && (pready || timeout);
  assign rdata   = prdata;

  // SETUP phase drives the caller's values directly; ACCESS replays the captured copy.
  assign psel    = start || access_q;
  assign penable = access_q;
  assign paddr   = access_q ? addr_q  : (start ? addr  : '0);
  assign pwrite  = access_q ? we_q    : (start && we);
  assign pwdata  = access_q ? wdata_q : (start ? wdata : '0);

  always_comb begin
    err = ERR_NONE;
    if (done) begin
      if (!pready)      err = ERR_TIMEOUT;
      else if (pslverr) err = ERR_SLVERR;
    end
  end

  // NOTE: state registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      access_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
    end else if (start) begin
      access_q <= 1'b1;
      we_q     <= we;
      addr_q   <= addr;
      wdata_q  <= wdata;
      wait_q   <= '0;
    end else if (done) begin
      access_q <= 1'b0;
    end else if (access_q) begin
      wait_q   <= wait_q + WW'(1);
    end
  end

endmodule

// File: rtl/uart_cfg_apb_sequencer.sv
// APB master that polls UART STATUS until idle, then programs SETUP from one request.
// Defining CFG_READBACK_EN adds a SETUP read-back and reports mismatches as err 11.
module uart_cfg_apb_sequencer
  import uart_cfg_pkg::*;
#(
  parameter int          APB_AW     = 12,
  parameter int unsigned BASE_ADDR  = 'h000,
  parameter int          POLL_MAX   = 1023,
  parameter int          PREADY_MAX = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  uart_cfg_apb_sequencer_if.master  bus
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [APB_AW-1:0] STATUS_ADDR = APB_AW'(BASE_ADDR + STATUS_OFS);
  localparam logic [APB_AW-1:0] SETUP_ADDR  = APB_AW'(BASE_ADDR + SETUP_OFS);

  state_e      state_q, state_d;
  setup_cfg_t  cfg_q, cfg_d;
  logic [PW-1:0] poll_q, poll_d, poll_inc;
  err_code_e   err_q, err_d;

  logic              x_start, x_we, x_done;
  logic [APB_AW-1:0] x_addr;
  logic [31:0]       x_wdata, x_rdata;
  err_code_e         x_err;

  logic        busy;
  logic [31:0] setup_word;

  assign busy       = |(x_rdata & STATUS_BUSY_MASK);
  assign setup_word = pack_setup(cfg_q);
  assign poll_inc   = poll_q + PW'(1);

`ifdef CFG_READBACK_EN
  logic rb_mismatch;
  assign rb_mismatch = |((x_rdata ^ setup_word) & SETUP_RB_MASK);
`endif

  uart_cfg_apb_xfer #(
    .APB_AW     (APB_AW),
    .PREADY_MAX (PREADY_MAX)
  ) u_xfer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (x_start),
    .we      (x_we),
    .addr    (x_addr),
    .wdata   (x_wdata),
    .done    (x_done),
    .rdata   (x_rdata),
    .err     (x_err),
    .paddr   (bus.paddr_o),
    .psel    (bus.psel_o),
    .penable (bus.penable_o),
    .pwrite  (bus.pwrite_o),
    .pwdata  (bus.pwdata_o),
    .prdata  (bus.prdata_i),
    .pready  (bus.pready_i),
    .pslverr (bus.pslverr_i)
  );

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.err_code_o  = err_q;
  assign bus.err_o       = (err_q != ERR_NONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      poll_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    poll_d  = poll_q;
    err_d   = err_q;
    x_start = 1'b0;
    x_we    = 1'b0;
    x_addr  = '0;
    x_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          cfg_d.clkdiv = bus.req_clkdiv_i;
          cfg_d.rxen   = bus.req_rxen_i;
          cfg_d.txen   = bus.req_txen_i;
          cfg_d.stop   = bus.req_stop_i;
          cfg_d.bits   = bus.req_bits_i;
          cfg_d.parity = bus.req_parity_i;
          poll_d       = '0;
          err_d        = ERR_NONE;
          state_d      = S_POLL_SETUP;
        end
      end

      S_POLL_SETUP: begin
        x_start = 1'b1;
        x_addr  = STATUS_ADDR;
        state_d = S_POLL_ACCESS;
      end

      S_POLL_ACCESS: begin
        if (x_done) begin
          poll_d = poll_inc;
          if (x_err != ERR_NONE) begin
            err_d   = x_err;
            state_d = S_DONE;
          end else if (!busy) begin
            state_d = S_WR_SETUP;
          end else if (poll_inc == PW'(POLL_MAX)) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_DONE;
          end else begin
            state_d = S_POLL_SETUP;
          end
        end
      end

      S_WR_SETUP: begin
        x_start = 1'b1;
        x_we    = 1'b1;
        x_addr  = SETUP_ADDR;
        x_wdata = setup_word;
        state_d = S_WR_ACCESS;
      end

      S_WR_ACCESS: begin
        if (x_done) begin
          if (x_err != ERR_NONE) begin
            err_d   = x_err;
            state_d = S_DONE;
          end else begin
`ifdef CFG_READBACK_EN
            state_d = S_RD_SETUP;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef CFG_READBACK_EN
      S_RD_SETUP: begin
        x_start = 1'b1;
        x_addr  = SETUP_ADDR;
        state_d = S_RD_ACCESS;
      end

      S_RD_ACCESS: begin
        if (x_done) begin
          if (x_err != ERR_NONE) err_d = x_err;
          else if (rb_mismatch)  err_d = ERR_MISMATCH;
          state_d = S_DONE;
        end
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cfg_apb_sequencer.sv
// Scoreboard bench for uart_cfg_apb_sequencer: expected APB accesses and completions are
// queued per request and compared by a monitor as the DUT produces them.
module tb_uart_cfg_apb_sequencer;

  localparam int          APB_AW     = 12;
  localparam int unsigned BASE       = 'h100;
  localparam int          POLL_MAX   = 4;
  localparam int          PREADY_MAX = 8;
  localparam logic [11:0] STATUS_A   = 12'h120;
  localparam logic [11:0] SETUP_A    = 12'h124;
`ifdef CFG_READBACK_EN
  localparam bit RB     = 1'b1;
  localparam int RB_LAT = 2;
`else
  localparam bit RB     = 1'b0;
  localparam int RB_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cfg_apb_sequencer_if #(.APB_AW(APB_AW)) bus ();

  uart_cfg_apb_sequencer #(
    .APB_AW     (APB_AW),
    .BASE_ADDR  (BASE),
    .POLL_MAX   (POLL_MAX),
    .PREADY_MAX (PREADY_MAX)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Slave behaviour knobs (set by the test tasks).
  int          busy_reads;
  logic [31:0] busy_val;
  bit          stuck, stall, err_on_wr, rb_flip;
  // Slave state.
  int          rd_cnt;
  logic [31:0] setup_reg;

  wire xfer_ok = bus.psel_o & bus.penable_o & bus.pready_i;

  assign bus.pready_i  = bus.psel_o & bus.penable_o & !stall;
  assign bus.pslverr_i = bus.pready_i & bus.pwrite_o & err_on_wr;
  assign bus.prdata_i  = (bus.paddr_o == STATUS_A)
                       ? ((stuck || rd_cnt < busy_reads) ? busy_val : 32'h0)
                       : (setup_reg ^ {31'h0, rb_flip});

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt    <= 0;
      setup_reg <= '0;
    end else begin
      if (bus.req_valid_i && bus.req_ready_o) rd_cnt <= 0;
      else if (xfer_ok && !bus.pwrite_o && bus.paddr_o == STATUS_A) rd_cnt <= rd_cnt + 1;
      if (xfer_ok && bus.pwrite_o && !bus.pslverr_i) setup_reg <= bus.pwdata_o;
    end
  end

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [1:0] done_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push_apb(input logic [11:0] a, input logic w, input logic [31:0] d);
    apb_exp_t e;
    e.addr = a; e.wr = w; e.wdata = d;
    apb_q.push_back(e);
  endtask

  // Expected sequence for a sequence that reaches the SETUP write cleanly.
  task automatic push_ok_seq(input int polls, input logic [31:0] word);
    for (int i = 0; i < polls; i++) push_apb(STATUS_A, 1'b0, 32'h0);
    push_apb(SETUP_A, 1'b1, word);
    if (RB) push_apb(SETUP_A, 1'b0, 32'h0);
  endtask

  task automatic monitor();
    apb_exp_t   e;
    logic [1:0] c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (xfer_ok) begin
          n_checks++;
          if (apb_q.size() == 0) begin
            n_fail++;
            $display("FAIL apb_unexpected: addr=%h wr=%b wdata=%h, required no access",
                     bus.paddr_o, bus.pwrite_o, bus.pwdata_o);
          end else begin
            e = apb_q.pop_front();
            if (bus.paddr_o !== e.addr || bus.pwrite_o !== e.wr ||
                (e.wr && bus.pwdata_o !== e.wdata)) begin
              n_fail++;
              $display("FAIL apb_access: got addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                       bus.paddr_o, bus.pwrite_o, bus.pwdata_o, e.addr, e.wr, e.wdata);
            end
          end
        end
        if (bus.done_o) begin
          n_checks++;
          if (done_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: err_code=%b, required no done_o", bus.err_code_o);
          end else begin
            c = done_q.pop_front();
            if (bus.err_code_o !== c || bus.err_o !== (c != 2'b00)) begin
              n_fail++;
              $display("FAIL done_status: got err=%b code=%b, required err=%b code=%b",
                       bus.err_o, bus.err_code_o, (c != 2'b00), c);
            end
          end
        end
      end
    end
  endtask

  task automatic send_req(input logic [15:0] div, input logic [1:0] bits,
                          input logic par, input logic stp, input logic tx, input logic rx);
    @(negedge clk);
    bus.req_clkdiv_i = div;  bus.req_bits_i = bits; bus.req_parity_i = par;
    bus.req_stop_i   = stp;  bus.req_txen_i = tx;   bus.req_rxen_i   = rx;
    bus.req_valid_i  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat, output int acc, output bit seen);
    lat = 0; acc = 0; seen = 1'b0;
    while (!seen && lat < bound) begin
      @(negedge clk);
      lat++;
      if (bus.psel_o && bus.penable_o) acc++;
      if (bus.done_o) seen = 1'b1;
    end
  endtask

  task automatic check_done(input string name, input bit seen, input int lat, input int exp_lat);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: no done_o within bound, required done at cycle %0d", name, exp_lat);
    end else if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: done at cycle %0d, required cycle %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready_o, bus.psel_o, bus.penable_o, bus.done_o, bus.err_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_in_reset: ready/psel/pen/done/err=%b, required 10000",
               {bus.req_ready_o, bus.psel_o, bus.penable_o, bus.done_o, bus.err_o});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready_o, bus.psel_o, bus.penable_o, bus.pwrite_o, bus.done_o, bus.err_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/psel/pen/pwrite/done/err=%b, required 100000",
               {bus.req_ready_o, bus.psel_o, bus.penable_o, bus.pwrite_o, bus.done_o, bus.err_o});
    end
    n_checks++;
    if (bus.paddr_o !== 12'h0 || bus.pwdata_o !== 32'h0 || bus.err_code_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwdata=%h code=%b, required 0/0/00",
               bus.paddr_o, bus.pwdata_o, bus.err_code_o);
    end
  endtask

  task automatic test_basic();
    int lat, acc; bit seen;
    busy_reads = 0; stuck = 0; stall = 0; err_on_wr = 0; rb_flip = 0;
    push_ok_seq(1, 32'h01B2_0307);
    done_q.push_back(2'b00);
    send_req(16'h01B2, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(40, lat, acc, seen);
    check_done("basic", seen, lat, 5 + RB_LAT);
    n_checks++;
    if (bus.psel_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_cycle: psel=%b ready=%b, required 0/0", bus.psel_o, bus.req_ready_o);
    end
  endtask

  task automatic test_poll_busy();
    int lat, acc; bit seen;
    busy_reads = 3; busy_val = 32'h1;
    push_ok_seq(4, 32'h0010_0108);
    done_q.push_back(2'b00);
    send_req(16'h0010, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_done(60, lat, acc, seen);
    check_done("poll_busy", seen, lat, 11 + RB_LAT);
  endtask

  task automatic test_poll_timeout();
    int lat, acc; bit seen;
    stuck = 1; busy_val = 32'h2;
    for (int i = 0; i < 4; i++) push_apb(STATUS_A, 1'b0, 32'h0);
    done_q.push_back(2'b10);
    send_req(16'h0100, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(60, lat, acc, seen);
    check_done("poll_timeout", seen, lat, 9);
    n_checks++;
    if (apb_q.size() != 0) begin
      n_fail++;
      $display("FAIL poll_timeout_polls: %0d expected accesses missing, required 0", apb_q.size());
    end
    stuck = 0;
  endtask

  task automatic test_slverr();
    int lat, acc, extra; bit seen;
    busy_reads = 0; err_on_wr = 1;
    push_apb(STATUS_A, 1'b0, 32'h0);
    push_apb(SETUP_A, 1'b1, 32'h1234_030E);
    done_q.push_back(2'b01);
    send_req(16'h1234, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(40, lat, acc, seen);
    check_done("slverr", seen, lat, 5);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.psel_o) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL slverr_no_access: psel high %0d cycles after done, required 0", extra);
    end
    n_checks++;
    if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'b01) begin
      n_fail++;
      $display("FAIL slverr_held: err=%b code=%b in idle, required 1/01", bus.err_o, bus.err_code_o);
    end
    err_on_wr = 0;
  endtask

  task automatic test_back_to_back();
    int lat, acc; bit seen;
    push_ok_seq(1, 32'hFFFF_020B);
    done_q.push_back(2'b00);
    send_req(16'hFFFF, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.err_code_o !== 2'b00 || bus.psel_o !== 1'b1 || bus.penable_o !== 1'b0 ||
        bus.paddr_o !== STATUS_A) begin
      n_fail++;
      $display("FAIL b2b_start: code=%b psel=%b pen=%b paddr=%h, required 00/1/0/%h",
               bus.err_code_o, bus.psel_o, bus.penable_o, bus.paddr_o, STATUS_A);
    end
    wait_done(40, lat, acc, seen);
    check_done("b2b_first", seen, lat + 1, 5 + RB_LAT);
    // Present the next request in the done cycle; it must be taken the following cycle.
    push_ok_seq(1, 32'h0001_0304);
    done_q.push_back(2'b00);
    bus.req_clkdiv_i = 16'h0001; bus.req_bits_i = 2'b10; bus.req_parity_i = 1'b0;
    bus.req_stop_i   = 1'b0;     bus.req_txen_i = 1'b1;  bus.req_rxen_i   = 1'b1;
    bus.req_valid_i  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: ready=%b cycle after done, required 1", bus.req_ready_o);
    end
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.psel_o !== 1'b1 || bus.penable_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: psel=%b pen=%b ready=%b, required 1/0/0",
               bus.psel_o, bus.penable_o, bus.req_ready_o);
    end
    wait_done(40, lat, acc, seen);
    check_done("b2b_second", seen, lat + 1, 5 + RB_LAT);
  endtask

  task automatic test_pready_timeout();
    int lat, acc, dones; bit seen;
    stall = 1;
    done_q.push_back(2'b10);
    send_req(16'h0200, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(40, lat, acc, seen);
    check_done("pready_timeout", seen, lat, 10);
    n_checks++;
    if (acc != PREADY_MAX || bus.psel_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pready_wait: %0d access cycles psel=%b at done, required %0d/0",
               acc, bus.psel_o, PREADY_MAX);
    end
    // Retry, then reset asynchronously in the middle of the ACCESS phase.
    send_req(16'h0200, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.psel_o !== 1'b1 || bus.penable_o !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_access: psel=%b pen=%b, required 1/1", bus.psel_o, bus.penable_o);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0 || bus.req_ready_o !== 1'b1 ||
        bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: psel=%b pen=%b ready=%b done=%b, required 0/0/1/0",
               bus.psel_o, bus.penable_o, bus.req_ready_o, bus.done_o);
    end
    @(negedge clk);
    stall = 0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    n_checks++;
    if (dones != 0 || bus.err_code_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d done pulses code=%b, required 0/00", dones, bus.err_code_o);
    end
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback();
    int lat, acc; bit seen;
    rb_flip = 1;
    push_ok_seq(1, 32'h01B2_0307);
    done_q.push_back(2'b11);
    send_req(16'h01B2, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(40, lat, acc, seen);
    check_done("readback_mismatch", seen, lat, 7);
    rb_flip = 0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_clkdiv_i = '0; bus.req_bits_i = '0;
    bus.req_parity_i = 1'b0; bus.req_stop_i = 1'b0; bus.req_txen_i = 1'b0; bus.req_rxen_i = 1'b0;
    busy_reads = 0; busy_val = '0; stuck = 0; stall = 0; err_on_wr = 0; rb_flip = 0;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_poll_busy();
    test_poll_timeout();
    test_slverr();
    test_back_to_back();
    test_pready_timeout();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (apb_q.size() != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d accesses and %0d completions outstanding, required 0/0",
               apb_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
